// File: rtl/rv_ifu_fetchq.sv
`default_nettype none
// ============================================================================
// Module   : rv_ifu_fetchq
// Purpose  : Pipelined instruction fetch with credit-gated I_MEM requests,
//            an in-order PC-tagged instruction queue and redirect squashing.
// Revision : 1.0
// ============================================================================
module rv_ifu_fetchq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4,
  localparam int unsigned CW      = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic [CW-1:0] queue_count
);

  localparam int unsigned AW       = $clog2(QDEPTH);
  localparam logic [CW:0] c_qdepth = (CW+1)'(QDEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic          r_run;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_q_inst [QDEPTH];
  logic [31:0]   r_q_pc   [QDEPTH];

  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occupancy;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_in_flight_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [31:0]   w_redirect_pc;
  logic          w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  // In-flight requests hold queue credit, so an accepted fetch always has a slot.
  assign w_occupancy    = {1'b0, r_count} + {1'b0, r_in_flight};
  assign imem_req_valid = r_run & ~redirect_valid & (w_occupancy < c_qdepth);
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_rsp  = imem_rsp_valid & (r_in_flight != '0);
  assign w_push = w_rsp & (r_drop == '0) & ~redirect_valid;

  assign inst_valid  = (r_count != '0);
  assign w_pop       = inst_valid & inst_ready & ~redirect_valid;
  assign inst        = r_q_inst[r_rd_ptr];
  assign inst_pc     = r_q_pc[r_rd_ptr];
  assign queue_count = r_count;

  always_comb begin
    w_in_flight_nxt = r_in_flight + CW'(w_accept) - CW'(w_rsp);
    w_count_nxt     = r_count;
    w_drop_nxt      = r_drop;
    if (redirect_valid) begin
      w_count_nxt = '0;
      // Everything still outstanding after this edge belongs to the old stream.
      w_drop_nxt  = r_in_flight - CW'(w_rsp);
    end else begin
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        w_count_nxt = r_count - CW'(1);
      end
      if (w_rsp && (r_drop != '0)) begin
        w_drop_nxt = r_drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_run       <= 1'b0;
      r_count     <= '0;
      r_in_flight <= '0;
      r_drop      <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_run       <= 1'b1;
      r_count     <= w_count_nxt;
      r_in_flight <= w_in_flight_nxt;
      r_drop      <= w_drop_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Queue storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (rst) w_occupancy <= c_qdepth);
  a_drop:   assert property (@(posedge clk) disable iff (rst) r_drop <= r_in_flight);

endmodule
`default_nettype wire
